// File: rtl/dm_pipe_pkg.sv
// Shared constants for the pipelined data memory: access op codes, latency cap,
// FSM states and alignment helpers.
package dm_pipe_pkg;

  localparam logic [2:0] OP_BT   = 3'b000;
  localparam logic [2:0] OP_HF   = 3'b001;
  localparam logic [2:0] OP_WD   = 3'b010;
  localparam logic [2:0] OP_UBT  = 3'b100;
  localparam logic [2:0] OP_UHF  = 3'b101;
  localparam logic [2:0] OP_NONE = 3'b111;

  localparam int LAT_MAX = 3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic op_is_access(input logic [2:0] op);
    case (op)
      OP_WD, OP_HF, OP_BT, OP_UHF, OP_UBT: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_WD:         return lane != 2'b00;
      OP_HF, OP_UHF: return lane[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_pipe_lane.sv
// Combinational lane logic: store merge into the old word and load extract/extend.
module dm_lane
  import dm_pipe_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] ld_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    merged = old_word;
    case (op)
      OP_WD:          merged = wdata;
      OP_HF, OP_UHF:  merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      OP_BT, OP_UBT:  merged[{lane, 3'b000} +: 8] = wdata[7:0];
      default:        merged = old_word;
    endcase
  end

  // Half select uses lane[1] only, so a misaligned lane can never index past bit 31.
  always_comb begin
    byte_v  = old_word[{lane, 3'b000} +: 8];
    half_v  = old_word[{lane[1], 4'b0000} +: 16];
    ld_word = wdata;
    case (op)
      OP_WD:   ld_word = old_word;
      OP_HF:   ld_word = {{16{half_v[15]}}, half_v};
      OP_UHF:  ld_word = {16'h0000, half_v};
      OP_BT:   ld_word = {{24{byte_v[7]}}, byte_v};
      OP_UBT:  ld_word = {24'h000000, byte_v};
      default: ld_word = wdata;
    endcase
  end

endmodule

// File: rtl/dm_pipe.sv
// MEM-stage data memory: valid/ready requests, LAT-cycle responses, alignment
// exceptions, zero-clear sweep after reset and a store trace port.
module dm_pipe #(
  parameter int AW    = 12,
  parameter int LAT   = 1,
  parameter int TRACE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        rsp_vld,
  output logic [31:0] rdata,
  output logic        exc,
  output logic        busy,
  output logic        trc_vld,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_addr,
  output logic [31:0] trc_data
);
  import dm_pipe_pkg::*;

  // state    | meaning
  // ST_CLEAR | zeroing ram[cnt], one word per cycle; requests blocked
  // ST_RUN   | normal operation, one request accepted per cycle

  localparam int LC = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [31:0]     mem [2**AW];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            accept, mis, commit;
  logic [31:0]     old_word, merged, ld_word;
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdat;

  logic [LC-1:0]   vld_q, vld_d, exc_q, exc_d;
  logic [31:0]     dat_q [LC];
  logic [31:0]     dat_d [LC];

  logic            trc_vld_q, trc_vld_d;
  logic [31:0]     trc_pc_q, trc_pc_d, trc_addr_q, trc_addr_d, trc_data_q, trc_data_d;

  logic            unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign idx      = addr[AW+1:2];
  assign lane     = addr[1:0];
  assign req_rdy  = (state_q == ST_RUN);
  assign busy     = (state_q == ST_CLEAR);
  assign accept   = req_vld && req_rdy;
  assign mis      = op_misaligned(op, lane);
  assign commit   = accept && we && !mis && op_is_access(op);
  assign old_word = mem[idx];

  dm_lane u_lane (
    .old_word (old_word),
    .wdata    (wdata),
    .op       (op),
    .lane     (lane),
    .merged   (merged),
    .ld_word  (ld_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes are gated by rst so a reset edge never commits a store or sweep word.
  always_comb begin
    mem_we   = rst && ((state_q == ST_CLEAR) || commit);
    mem_widx = (state_q == ST_CLEAR) ? cnt_q : idx;
    mem_wdat = (state_q == ST_CLEAR) ? 32'h0 : merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdat;
  end

  always_comb begin
    vld_d = '0;
    exc_d = '0;
    for (int i = 0; i < LC; i++) dat_d[i] = '0;
    vld_d[0] = accept;
    exc_d[0] = accept && mis;
    dat_d[0] = (accept && !we && !mis) ? ld_word : 32'h0;
    for (int i = 1; i < LC; i++) begin
      vld_d[i] = vld_q[i-1];
      exc_d[i] = exc_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      exc_q <= '0;
      for (int i = 0; i < LC; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      exc_q <= exc_d;
      for (int i = 0; i < LC; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign rsp_vld = vld_q[LC-1];
  assign exc     = exc_q[LC-1];
  assign rdata   = dat_q[LC-1];

  always_comb begin
    trc_vld_d  = commit && (TRACE != 0);
    trc_pc_d   = trc_pc_q;
    trc_addr_d = trc_addr_q;
    trc_data_d = trc_data_q;
    if (trc_vld_d) begin
      trc_pc_d   = pc;
      trc_addr_d = {{(30-AW){1'b0}}, idx, 2'b00};
      trc_data_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      trc_vld_q  <= 1'b0;
      trc_pc_q   <= '0;
      trc_addr_q <= '0;
      trc_data_q <= '0;
    end else begin
      trc_vld_q  <= trc_vld_d;
      trc_pc_q   <= trc_pc_d;
      trc_addr_q <= trc_addr_d;
      trc_data_q <= trc_data_d;
    end
  end

  assign trc_vld  = trc_vld_q;
  assign trc_pc   = trc_pc_q;
  assign trc_addr = trc_addr_q;
  assign trc_data = trc_data_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe: dut_a (AW=4, LAT=3) and dut_b (AW=12, LAT=2)
// share the request bus and have separate resets.
module tb_dm_pipe;
  import dm_pipe_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_exc;
    logic        exp_trc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, req_vld, we;
  logic [2:0]  op;
  logic [31:0] addr, wdata, pc;

  logic        a_req_rdy, a_rsp_vld, a_exc, a_busy, a_trc_vld;
  logic [31:0] a_rdata, a_trc_pc, a_trc_addr, a_trc_data;
  logic        b_req_rdy, b_rsp_vld, b_exc, b_busy, b_trc_vld;
  logic [31:0] b_rdata, b_trc_pc, b_trc_addr, b_trc_data;

  dm_pipe #(.AW(4), .LAT(3), .TRACE(1)) dut_a (
    .clk(clk), .rst(rst_a), .req_vld(req_vld), .req_rdy(a_req_rdy), .we(we), .op(op),
    .addr(addr), .wdata(wdata), .pc(pc), .rsp_vld(a_rsp_vld), .rdata(a_rdata), .exc(a_exc),
    .busy(a_busy), .trc_vld(a_trc_vld), .trc_pc(a_trc_pc), .trc_addr(a_trc_addr),
    .trc_data(a_trc_data)
  );

  dm_pipe #(.AW(12), .LAT(2), .TRACE(1)) dut_b (
    .clk(clk), .rst(rst_b), .req_vld(req_vld), .req_rdy(b_req_rdy), .we(we), .op(op),
    .addr(addr), .wdata(wdata), .pc(pc), .rsp_vld(b_rsp_vld), .rdata(b_rdata), .exc(b_exc),
    .busy(b_busy), .trc_vld(b_trc_vld), .trc_pc(b_trc_pc), .trc_addr(b_trc_addr),
    .trc_data(b_trc_data)
  );

  logic        sel;
  logic        o_rdy, o_vld, o_exc, o_busy, o_trc;
  logic [31:0] o_rdata, o_trc_pc, o_trc_addr, o_trc_data;
  assign o_rdy      = sel ? b_req_rdy  : a_req_rdy;
  assign o_vld      = sel ? b_rsp_vld  : a_rsp_vld;
  assign o_exc      = sel ? b_exc      : a_exc;
  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_trc      = sel ? b_trc_vld  : a_trc_vld;
  assign o_rdata    = sel ? b_rdata    : a_rdata;
  assign o_trc_pc   = sel ? b_trc_pc   : a_trc_pc;
  assign o_trc_addr = sel ? b_trc_addr : a_trc_addr;
  assign o_trc_data = sel ? b_trc_data : a_trc_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One request on the selected DUT: checks acceptance, trace pulse, latency,
  // response payload and that outputs return to 0 afterwards.
  task automatic do_req(input logic s, input int lat, input vec_t v, input int id);
    string nm;
    int    n;
    nm  = $sformatf("req%0d", id);
    sel = s;
    @(negedge clk);
    req_vld = 1'b1; we = v.we; op = v.op; addr = v.addr; wdata = v.wdata; pc = 32'h1000 + id;
    chk({nm, " req_rdy"}, {31'b0, o_rdy}, 32'd1);
    @(negedge clk);
    req_vld = 1'b0;
    chk({nm, " trc_vld"}, {31'b0, o_trc}, {31'b0, v.exp_trc});
    n = 1;
    while (!o_vld && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " rdata"}, o_rdata, v.exp_rdata);
    chk({nm, " exc"}, {31'b0, o_exc}, {31'b0, v.exp_exc});
    @(negedge clk);
    chk({nm, " rsp_vld drop"}, {31'b0, o_vld}, 32'd0);
    chk({nm, " rdata idle"}, o_rdata, 32'd0);
  endtask

  vec_t vecs [22];
  int   na, nb, bad_rdy, bad_vld;
  logic [5:0] raw_v;

  initial begin
    vecs[0]  = '{1'b1, OP_WD,   32'h10,  32'h12345678, 32'h0,        1'b0, 1'b1};
    vecs[1]  = '{1'b1, OP_BT,   32'h13,  32'h000000AB, 32'h0,        1'b0, 1'b1};
    vecs[2]  = '{1'b1, OP_HF,   32'h10,  32'h0000CDEF, 32'h0,        1'b0, 1'b1};
    vecs[3]  = '{1'b0, OP_WD,   32'h10,  32'h0,        32'hAB34CDEF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, OP_BT,   32'h13,  32'h0,        32'hFFFFFFAB, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, OP_UBT,  32'h13,  32'h0,        32'h000000AB, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_HF,   32'h10,  32'h0,        32'hFFFFCDEF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, OP_UHF,  32'h12,  32'h0,        32'h0000AB34, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_BT,   32'h11,  32'h0,        32'hFFFFFFCD, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, OP_UBT,  32'h10,  32'h0,        32'h000000EF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, OP_NONE, 32'h10,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[11] = '{1'b1, OP_WD,   32'h102, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{1'b0, OP_WD,   32'h100, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b0, OP_HF,   32'h21,  32'h0,        32'h0,        1'b1, 1'b0};
    vecs[14] = '{1'b1, 3'b011,  32'h10,  32'h11111111, 32'h0,        1'b0, 1'b0};
    vecs[15] = '{1'b0, OP_WD,   32'h10,  32'h0,        32'hAB34CDEF, 1'b0, 1'b0};
    vecs[16] = '{1'b1, OP_HF,   32'h12,  32'h00009999, 32'h0,        1'b0, 1'b1};
    vecs[17] = '{1'b0, OP_WD,   32'h10,  32'h0,        32'h9999CDEF, 1'b0, 1'b0};
    vecs[18] = '{1'b0, OP_WD,   32'h11,  32'h0,        32'h0,        1'b1, 1'b0};
    vecs[19] = '{1'b1, OP_UHF,  32'h13,  32'h00004444, 32'h0,        1'b1, 1'b0};
    vecs[20] = '{1'b1, OP_UBT,  32'h11,  32'h00000077, 32'h0,        1'b0, 1'b1};
    vecs[21] = '{1'b0, OP_WD,   32'h10,  32'h0,        32'h999977EF, 1'b0, 1'b0};

    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; req_vld = 1'b0; we = 1'b0;
    op = OP_WD; addr = '0; wdata = '0; pc = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, a_busy}, 32'd1);
    chk("reset req_rdy", {31'b0, a_req_rdy}, 32'd0);
    chk("reset rsp_vld", {31'b0, a_rsp_vld}, 32'd0);
    chk("reset rdata", a_rdata, 32'd0);
    chk("reset exc", {31'b0, a_exc}, 32'd0);
    chk("reset trc_vld", {31'b0, a_trc_vld}, 32'd0);
    chk("reset busy b", {31'b0, b_busy}, 32'd1);

    rst_a = 1'b1; rst_b = 1'b1;
    na = 0; nb = 0;
    while (b_busy && nb < 5000) begin
      if (a_busy) na++;
      nb++;
      @(negedge clk);
    end
    chk("sweep len a", na, 16);
    chk("sweep len b", nb, 4096);

    for (int i = 0; i < 16; i++)
      do_req(1'b0, 3, '{1'b1, OP_WD, 32'(i*4), 32'hA5A50000 | 32'(i), 32'h0, 1'b0, 1'b1}, 100 + i);

    @(negedge clk); rst_a = 1'b0;
    @(negedge clk);
    chk("rst trc_pc", a_trc_pc, 32'd0);
    chk("rst trc_addr", a_trc_addr, 32'd0);
    chk("rst trc_data", a_trc_data, 32'd0);
    rst_a = 1'b1;
    na = 0; bad_rdy = 0;
    while (a_busy && na < 40) begin
      if (a_req_rdy) bad_rdy++;
      na++;
      @(negedge clk);
    end
    chk("resweep len", na, 16);
    chk("resweep req_rdy", bad_rdy, 0);
    for (int i = 0; i < 16; i++)
      do_req(1'b0, 3, '{1'b0, OP_WD, 32'(i*4), 32'h0, 32'h0, 1'b0, 1'b0}, 200 + i);

    for (int i = 0; i < 22; i++) do_req(1'b0, 3, vecs[i], i);

    // Back-to-back store then load of the same word, LAT=3.
    sel = 1'b0;
    raw_v = 6'b011000;
    @(negedge clk);
    req_vld = 1'b1; we = 1'b1; op = OP_WD; addr = 32'h40; wdata = 32'hDEADBEEF; pc = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) we = 1'b0;
      if (c == 2) req_vld = 1'b0;
      chk($sformatf("raw vld c%0d", c), {31'b0, a_rsp_vld}, {31'b0, raw_v[c]});
      chk($sformatf("raw rdata c%0d", c), a_rdata, (c == 4) ? 32'hDEADBEEF : 32'h0);
    end

    // Trace with address wrap on dut_b.
    sel = 1'b1;
    @(negedge clk);
    req_vld = 1'b1; we = 1'b1; op = OP_WD; addr = 32'h4004; wdata = 32'h55; pc = 32'h3000;
    @(negedge clk);
    req_vld = 1'b0;
    chk("trc vld", {31'b0, o_trc}, 32'd1);
    chk("trc pc", o_trc_pc, 32'h3000);
    chk("trc addr", o_trc_addr, 32'h4);
    chk("trc data", o_trc_data, 32'h55);
    @(negedge clk);
    chk("trc pulse", {31'b0, o_trc}, 32'd0);
    chk("trc pc hold", o_trc_pc, 32'h3000);
    do_req(1'b1, 2, '{1'b0, OP_WD, 32'h4, 32'h0, 32'h55, 1'b0, 1'b0}, 300);

    // Reset one cycle after accepting a load on dut_b (LAT=2).
    sel = 1'b1;
    @(negedge clk);
    req_vld = 1'b1; we = 1'b0; op = OP_WD; addr = 32'h4; wdata = 32'h0;
    @(negedge clk);
    req_vld = 1'b0; rst_b = 1'b0;
    chk("flush early vld", {31'b0, b_rsp_vld}, 32'd0);
    @(negedge clk);
    chk("flush vld", {31'b0, b_rsp_vld}, 32'd0);
    chk("flush busy", {31'b0, b_busy}, 32'd1);
    chk("flush req_rdy", {31'b0, b_req_rdy}, 32'd0);
    rst_b = 1'b1;
    nb = 0; bad_vld = 0;
    while (b_busy && nb < 5000) begin
      if (b_rsp_vld) bad_vld++;
      nb++;
      @(negedge clk);
    end
    chk("flush sweep len", nb, 4096);
    chk("flush no rsp", bad_vld, 0);
    do_req(1'b1, 2, '{1'b0, OP_WD, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0}, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
